// File: rtl/mips_pkg.sv
// Shared types and encodings for the P7 hazard controller: stage shadow record,
// forward-select codes and the "operand not read" Tuse marker.
package mips_pkg;

  localparam int A_W = 5;
  localparam int T_W = 2;

  typedef logic [A_W-1:0] reg_addr_t;
  typedef logic [T_W-1:0] tnew_t;

  // D-stage forward selects
  localparam logic [1:0] FWD_D_GRF  = 2'd0;
  localparam logic [1:0] FWD_D_E    = 2'd1;
  localparam logic [1:0] FWD_D_M    = 2'd2;
  // E-stage forward selects
  localparam logic [1:0] FWD_E_NONE = 2'd0;
  localparam logic [1:0] FWD_E_M    = 2'd1;
  localparam logic [1:0] FWD_E_W    = 2'd2;

  localparam tnew_t TUSE_NONE = 2'd3;

  typedef struct packed {
    reg_addr_t a3;
    tnew_t     tnew;
    reg_addr_t rs;
    reg_addr_t rt;
  } stage_t;

  // A D-stage read depends on a stage's pending write to the same non-zero register.
  function automatic logic reads_hit(reg_addr_t addr, tnew_t tuse, reg_addr_t a3);
    return (addr != '0) && (tuse != TUSE_NONE) && (addr == a3);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One E/M/W shadow record: clears to a bubble on reset or clear, and can
// saturating-decrement Tnew as the record moves one stage down the pipe.
module hazard_stage_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   dec,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else begin
      q <= d;
      // NOTE: the later non-blocking write to q.tnew overrides the field from the line above.
      if (dec && d.tnew != '0) q.tnew <= d.tnew - tnew_t'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage P7 pipeline: tracks E/M/W write targets
// and the HI/LO busy window, and derives stall plus D- and E-stage forward selects.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_tnew,
  input  logic       d_md,
  input  logic       d_mult,
  input  logic       d_div,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       md_busy
);

  stage_t e_q, m_q, w_q, d_rec, w_in;
  logic [CNT_W-1:0] md_cnt;
  logic e_md_start, md_issue, rs_late, rt_late;
  logic stage_unused;

  assign d_rec = '{a3: d_a3, tnew: d_tnew, rs: d_rs, rt: d_rt};
  assign w_in  = '{a3: m_q.a3, tnew: '0, rs: m_q.rs, rt: m_q.rt};
  assign stage_unused = ^{m_q.rs, m_q.rt, w_q.tnew, w_q.rs, w_q.rt};

  hazard_stage_reg u_stage_e (
    .clk(clk), .reset(reset), .clear(flush | stall), .dec(1'b0), .d(d_rec), .q(e_q)
  );
  hazard_stage_reg u_stage_m (
    .clk(clk), .reset(reset), .clear(flush), .dec(1'b1), .d(e_q), .q(m_q)
  );
  hazard_stage_reg u_stage_w (
    .clk(clk), .reset(reset), .clear(flush), .dec(1'b0), .d(w_in), .q(w_q)
  );

  function automatic logic read_late(reg_addr_t addr, tnew_t tuse, stage_t e, stage_t m);
    return (reads_hit(addr, tuse, e.a3) && e.tnew > tuse) ||
           (reads_hit(addr, tuse, m.a3) && m.tnew > tuse);
  endfunction

  // A matching E stage shadows M even when its result is not ready yet.
  function automatic logic [1:0] sel_d(reg_addr_t addr, tnew_t tuse, stage_t e, stage_t m);
    if (reads_hit(addr, tuse, e.a3)) return (e.tnew == '0) ? FWD_D_E : FWD_D_GRF;
    if (reads_hit(addr, tuse, m.a3) && m.tnew == '0) return FWD_D_M;
    return FWD_D_GRF;
  endfunction

  function automatic logic [1:0] sel_e(reg_addr_t addr, stage_t m, stage_t w);
    if (addr != '0 && addr == m.a3 && m.tnew == '0) return FWD_E_M;
    if (addr != '0 && addr == w.a3) return FWD_E_W;
    return FWD_E_NONE;
  endfunction

  assign rs_late  = read_late(d_rs, d_tuse_rs, e_q, m_q);
  assign rt_late  = read_late(d_rt, d_tuse_rt, e_q, m_q);
  assign md_busy  = (md_cnt != '0) | e_md_start;
  assign stall    = rs_late | rt_late | (d_md & md_busy);

  assign fwd_rs_d = sel_d(d_rs, d_tuse_rs, e_q, m_q);
  assign fwd_rt_d = sel_d(d_rt, d_tuse_rt, e_q, m_q);
  assign fwd_rs_e = sel_e(e_q.rs, m_q, w_q);
  assign fwd_rt_e = sel_e(e_q.rt, m_q, w_q);

  assign md_issue = (d_mult | d_div) & ~stall & ~flush;

  // The count holds while the mult/div sits in E, so busy spans that cycle plus the full latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt     <= '0;
      e_md_start <= 1'b0;
    end else begin
      e_md_start <= md_issue;
      if (md_issue)
        md_cnt <= d_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      else if (!e_md_start && md_cnt != '0)
        md_cnt <= md_cnt - CNT_W'(1);
    end
  end

endmodule
